mac_scheduler: RTL
==================

Name: mac_scheduler

Overview:
- Sequences the shared 4-lane combinational `mac` datapath over a wide input spike vector for one neuron.
- On each accepted request it fetches one 128-bit weight word (4 × 32-bit) per group of 4 inputs from a synchronous weight memory, drives the `mac`, and accumulates the partial sums.
- When all groups are done it presents the 32-bit membrane-input sum on a valid/ready output.
- Sits between the neuron update stage and the weight memory/`mac` pair.

Parameters:
- NUM_INPUTS, 16, spike vector width; must be a multiple of 4.
- ADDR_W, 8, weight memory word-address width.
- NUM_GROUPS, NUM_INPUTS/4, derived localparam; number of MAC passes.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- start_valid  input  1  request valid.
- start_ready  output  1  high only in IDLE.
- spike_vector  input  NUM_INPUTS  spikes; captured on accept.
- weight_base  input  ADDR_W  weight word address of group 0; captured on accept.
- weight_rd_en  output  1  weight memory read strobe.
- weight_addr  output  ADDR_W  read address = base + group (mod 2^ADDR_W).
- weight_data  input  128  read data, valid the cycle after weight_rd_en.
- mac_spike_out  output  4  spike nibble for the current group, to `mac` spike_in.
- mac_weights_out  output  128  to `mac` weights_in.
- mac_result_in  input  32  combinational `mac` result.
- acc_out  output  32  accumulated sum.
- acc_valid  output  1  result valid.
- acc_ready  input  1  downstream accept.

Behaviour:
- Reset values: state=IDLE, start_ready=1, weight_rd_en=0, weight_addr=0, mac_spike_out=0, mac_weights_out=0, acc_out=0, acc_valid=0, group=0.
- RESET mid-operation aborts the request and returns to IDLE next cycle. No acc_valid is produced for the aborted request.
- Lane mapping: spike_vector bit 4*g+i gates weight_data[32i+31:32i] for group g.
- State IDLE:
  - On start_valid & start_ready: latch spike_vector and weight_base, set acc=0, g=0, go to FETCH.
- State FETCH:
  - Assert weight_rd_en=1 with weight_addr=base+g.
  - Next state ACCUM.
- State ACCUM:
  - mac_spike_out = spikes[4g+3:4g]; mac_weights_out = weight_data (registered mux, stable for the cycle).
  - acc <= acc + mac_result_in, modulo 2^32 (two's complement wrap, no saturation).
  - If g == NUM_GROUPS-1, go to DONE; else g++ and go to FETCH.
- State DONE:
  - acc_valid=1 and acc_out=acc, both held stable while acc_ready=0.
  - On acc_ready, go to IDLE; acc_valid deasserts the following cycle.
  - acc_out keeps its last value in IDLE.
- Outside ACCUM: mac_spike_out=0 and weight_rd_en=0 (except in FETCH).
- Latency: accept edge to acc_valid = 2*NUM_GROUPS+1 cycles (9 at default).
- Throughput: one request per 2*NUM_GROUPS+2 cycles minimum.
- start_valid asserted while busy is ignored; the request is not captured until the scheduler returns to IDLE.
- Simultaneous acc_ready and start_valid in DONE: the new request is not accepted that cycle (start_ready=0).

Optional Feature:
- Macro: MAC_SCHEDULER_ZERO_SKIP_EN.
- Defined: in FETCH, if the current spike nibble is 0, no read is issued and the group is skipped in one cycle (g++ or go to DONE if last).
  - All-zero vector: acc_valid after NUM_GROUPS+1 cycles with acc=0.
  - Latency becomes 1 + (#zero groups) + 2*(#nonzero groups) cycles.
- Undefined: every group is fetched and accumulated regardless of spikes. Latency is fixed.

Decomposition:
- Shared package snn_mac_pkg:
  - Constants MAC_LANES=4, WEIGHT_W=32, WEIGHT_WORD_W=128, ACC_W=32.
  - State enum typedef {IDLE, FETCH, ACCUM, DONE}.
- The existing `mac` stays external. No sub-module is needed; the FSM plus accumulator is a single module.

Test Plan:
- spike_vector=16'h0001, base=0x10, mem[0x10] lane0=64 (others 0): acc_out=64, acc_valid 9 cycles after accept, reads at addresses 0x10..0x13.
- spike_vector=16'hFFFF, every lane weight=1: acc_out=16. With MAC_SCHEDULER_ZERO_SKIP_EN, latency is still 9.
- spike_vector=16'h0011, group0 lane0=0xFFFFFFFF, group1 lane0=2: acc_out=0x00000001 (wrap).
- Valid result with acc_ready held 0 for 5 cycles: acc_valid and acc_out stay stable; start_valid pulses during that time are not accepted. Assert acc_ready: next cycle state=IDLE, start_ready=1.
- RESET asserted for 1 cycle while in the third ACCUM: next cycle all outputs are at reset values, no acc_valid; a new request then completes correctly (acc_out=18321983 for mem lane0=18321983, spike 16'h0001).
- With MAC_SCHEDULER_ZERO_SKIP_EN and spike_vector=16'h0000: weight_rd_en never asserts, acc_out=0, acc_valid 5 cycles after accept.

Source files
------------

// File: rtl/snn_mac_pkg.sv
// Shared types and widths for the spiking-neuron MAC datapath.
package snn_mac_pkg;

   localparam int MAC_LANES     = 4;
   localparam int WEIGHT_W      = 32;
   localparam int WEIGHT_WORD_W = 128;
   localparam int ACC_W         = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/mac_scheduler_if.sv
// Bundle of request, weight-memory, mac and result signals around mac_scheduler.
interface mac_scheduler_if #(
   parameter int NUM_INPUTS = 16,
   parameter int ADDR_W     = 8
);
   import snn_mac_pkg::*;

   logic                     start_valid;
   logic                     start_ready;
   logic [NUM_INPUTS-1:0]    spike_vector;
   logic [ADDR_W-1:0]        weight_base;
   logic                     weight_rd_en;
   logic [ADDR_W-1:0]        weight_addr;
   logic [WEIGHT_WORD_W-1:0] weight_data;
   logic [MAC_LANES-1:0]     mac_spike_out;
   logic [WEIGHT_WORD_W-1:0] mac_weights_out;
   logic [ACC_W-1:0]         mac_result_in;
   logic [ACC_W-1:0]         acc_out;
   logic                     acc_valid;
   logic                     acc_ready;

   modport master (
      output start_valid, spike_vector, weight_base, weight_data, mac_result_in, acc_ready,
      input  start_ready, weight_rd_en, weight_addr, mac_spike_out, mac_weights_out,
             acc_out, acc_valid
   );

   modport slave (
      input  start_valid, spike_vector, weight_base, weight_data, mac_result_in, acc_ready,
      output start_ready, weight_rd_en, weight_addr, mac_spike_out, mac_weights_out,
             acc_out, acc_valid
   );

endinterface

// File: rtl/mac_scheduler.sv
// Walks a neuron's spike vector 4 inputs at a time through the external mac, accumulating the sum.
// Build option MAC_SCHEDULER_ZERO_SKIP_EN: groups whose spike nibble is zero are skipped without a read.
module mac_scheduler
   import snn_mac_pkg::*;
#(
   parameter int NUM_INPUTS = 16,
   parameter int ADDR_W     = 8
) (
   input logic            CLK,
   input logic            RESET,
   mac_scheduler_if.slave bus
);

   localparam int NUM_GROUPS = NUM_INPUTS / MAC_LANES;
   localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

`ifdef MAC_SCHEDULER_ZERO_SKIP_EN
   localparam bit ZERO_SKIP = 1'b1;
`else
   localparam bit ZERO_SKIP = 1'b0;
`endif

   sched_state_e          state_q, state_d;
   logic [NUM_INPUTS-1:0] spikes_q, spikes_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [GRP_W-1:0]      grp_q, grp_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic                  weight_rd_en_q, weight_rd_en_d;
   logic [ADDR_W-1:0]     weight_addr_q, weight_addr_d;
   logic [MAC_LANES-1:0]  mac_spike_out_q, mac_spike_out_d;
   logic [ACC_W-1:0]      acc_out_q, acc_out_d;
   logic                  acc_valid_q, acc_valid_d;
   logic                  start_ready_q, start_ready_d;

   logic [GRP_W-1:0]      nxt_grp_s;
   logic [MAC_LANES-1:0]  cur_nib_s, nxt_nib_s;
   logic [ACC_W-1:0]      acc_sum_s;

   // A group needs a memory read unless zero-skip is built in and its spikes are all zero.
   function automatic logic read_needed(input logic [MAC_LANES-1:0] nib);
      return (ZERO_SKIP == 1'b0) || (nib != {MAC_LANES{1'b0}});
   endfunction

   assign nxt_grp_s = grp_q + GRP_W'(1);
   assign cur_nib_s = spikes_q[{grp_q, 2'b00} +: MAC_LANES];
   assign nxt_nib_s = spikes_q[{nxt_grp_s, 2'b00} +: MAC_LANES];
   assign acc_sum_s = acc_q + bus.mac_result_in;

   // Next-state and next-output computation for the scheduler FSM.
   always_comb begin
      state_d         = state_q;
      spikes_d        = spikes_q;
      base_d          = base_q;
      grp_d           = grp_q;
      acc_d           = acc_q;
      weight_rd_en_d  = 1'b0;
      weight_addr_d   = weight_addr_q;
      mac_spike_out_d = {MAC_LANES{1'b0}};
      acc_out_d       = acc_out_q;
      case (state_q)
         IDLE: begin
            if (bus.start_valid && start_ready_q) begin
               spikes_d       = bus.spike_vector;
               base_d         = bus.weight_base;
               grp_d          = {GRP_W{1'b0}};
               acc_d          = {ACC_W{1'b0}};
               weight_rd_en_d = read_needed(bus.spike_vector[MAC_LANES-1:0]);
               weight_addr_d  = bus.weight_base;
               state_d        = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            // A FETCH without a read in flight is a skipped all-zero group.
            if (weight_rd_en_q) begin
               mac_spike_out_d = cur_nib_s;
               state_d         = ACCUM;
            end else if (grp_q == LAST_GRP) begin
               acc_out_d = acc_q;
               state_d   = DONE;
            end else begin
               grp_d          = nxt_grp_s;
               weight_rd_en_d = read_needed(nxt_nib_s);
               weight_addr_d  = base_q + ADDR_W'(nxt_grp_s);
               state_d        = FETCH;
            end
         end
         ACCUM: begin
            acc_d = acc_sum_s;
            if (grp_q == LAST_GRP) begin
               acc_out_d = acc_sum_s;
               state_d   = DONE;
            end else begin
               grp_d          = nxt_grp_s;
               weight_rd_en_d = read_needed(nxt_nib_s);
               weight_addr_d  = base_q + ADDR_W'(nxt_grp_s);
               state_d        = FETCH;
            end
         end
         DONE: begin
            if (bus.acc_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      start_ready_d = (state_d == IDLE);
      acc_valid_d   = (state_d == DONE);
   end

   // State, datapath and registered outputs; RESET is synchronous and aborts any request.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q         <= IDLE;
         spikes_q        <= {NUM_INPUTS{1'b0}};
         base_q          <= {ADDR_W{1'b0}};
         grp_q           <= {GRP_W{1'b0}};
         acc_q           <= {ACC_W{1'b0}};
         weight_rd_en_q  <= 1'b0;
         weight_addr_q   <= {ADDR_W{1'b0}};
         mac_spike_out_q <= {MAC_LANES{1'b0}};
         acc_out_q       <= {ACC_W{1'b0}};
         acc_valid_q     <= 1'b0;
         start_ready_q   <= 1'b1;
      end else begin
         state_q         <= state_d;
         spikes_q        <= spikes_d;
         base_q          <= base_d;
         grp_q           <= grp_d;
         acc_q           <= acc_d;
         weight_rd_en_q  <= weight_rd_en_d;
         weight_addr_q   <= weight_addr_d;
         mac_spike_out_q <= mac_spike_out_d;
         acc_out_q       <= acc_out_d;
         acc_valid_q     <= acc_valid_d;
         start_ready_q   <= start_ready_d;
      end
   end

   assign bus.start_ready     = start_ready_q;
   assign bus.weight_rd_en    = weight_rd_en_q;
   assign bus.weight_addr     = weight_addr_q;
   assign bus.mac_spike_out   = mac_spike_out_q;
   // Memory data arrives during ACCUM, so the weight path is a mux selected by registered state.
   assign bus.mac_weights_out = (state_q == ACCUM) ? bus.weight_data : {WEIGHT_WORD_W{1'b0}};
   assign bus.acc_out         = acc_out_q;
   assign bus.acc_valid       = acc_valid_q;

endmodule
